// File: rtl/timing_study_pkg.sv
// timing_study_pkg: shared widths, timestamp/delay types and the saturating NLDM-style delay function
package timing_study_pkg;
  localparam int TIME_W = 32;
  localparam int TT_W = 16;
  localparam int CAP_W = 16;
  localparam int DLY_W = 16;
  typedef logic [TIME_W-1:0] ts_time_t;
  typedef logic [DLY_W-1:0] ts_delay_t;
  function automatic ts_delay_t calc_delay(input logic [31:0] tt, input logic [31:0] cap, input int unsigned d0,
                                           input int unsigned tt_shift, input int unsigned cap_shift,
                                           input int unsigned max_d);
    longint unsigned s;
    s = 64'(d0) + (64'(tt) >> tt_shift) + (64'(cap) >> cap_shift);
    return ts_delay_t'((s > 64'(max_d)) ? 64'(max_d) : s);
  endfunction
endpackage

// File: rtl/timing_study_board_if.sv
// timing_study_board_if: gate inputs/controls (master drives) and delayed output/timestamps (slave drives); meas_count only with TS_MEAS_COUNT_EN
interface timing_study_board_if #(
  parameter int TIME_W = timing_study_pkg::TIME_W,
  parameter int TT_W = timing_study_pkg::TT_W,
  parameter int CAP_W = timing_study_pkg::CAP_W
);
  logic din0, din1, fin_test, dout, busy, meas_valid;
  logic [TT_W-1:0] tt_val;
  logic [CAP_W-1:0] capa_charge_val;
  logic [TIME_W-1:0] start_time, stop_time;
`ifdef TS_MEAS_COUNT_EN
  logic [15:0] meas_count;
`endif
  modport master(
    output din0, din1, tt_val, capa_charge_val, fin_test,
    input dout, busy, start_time, stop_time, meas_valid
`ifdef TS_MEAS_COUNT_EN
    , meas_count
`endif
  );
  modport slave(
    input din0, din1, tt_val, capa_charge_val, fin_test,
    output dout, busy, start_time, stop_time, meas_valid
`ifdef TS_MEAS_COUNT_EN
    , meas_count
`endif
  );
endinterface

// File: rtl/timing_study_board_delay_model.sv
// ts_delay_model: combinational delay = min(D0 + tt_val>>TT_SHIFT + capa_charge_val>>CAP_SHIFT, MAX_DELAY)
module ts_delay_model #(
  parameter int TT_W = timing_study_pkg::TT_W,
  parameter int CAP_W = timing_study_pkg::CAP_W,
  parameter int unsigned D0 = 2,
  parameter int unsigned TT_SHIFT = 4,
  parameter int unsigned CAP_SHIFT = 6,
  parameter int unsigned MAX_DELAY = 1023
) (
  input  logic [TT_W-1:0]             tt_val,
  input  logic [CAP_W-1:0]            capa_charge_val,
  output timing_study_pkg::ts_delay_t delay
);
  import timing_study_pkg::*;
  assign delay = calc_delay(32'(tt_val), 32'(capa_charge_val), D0, TT_SHIFT, CAP_SHIFT, MAX_DELAY);
endmodule

// File: rtl/timing_study_board.sv
// timing_study_board: AND2 delay stand-in; clk/rst plus bus (din0/din1/tt_val/capa_charge_val/fin_test in, dout/busy/start_time/stop_time/meas_valid out, meas_count with TS_MEAS_COUNT_EN)
module timing_study_board #(
  parameter int TIME_W = timing_study_pkg::TIME_W,
  parameter int TT_W = timing_study_pkg::TT_W,
  parameter int CAP_W = timing_study_pkg::CAP_W,
  parameter int unsigned D0 = 2,
  parameter int unsigned TT_SHIFT = 4,
  parameter int unsigned CAP_SHIFT = 6,
  parameter int unsigned MAX_DELAY = 1023
) (
  input logic clk,
  input logic rst,
  timing_study_board_if.slave bus
);
  import timing_study_pkg::*;
  logic [1:0] din_q, din_d;
  logic target_q, target_d, dout_q, dout_d, busy_q, busy_d, mv_q, mv_d, new_target;
  logic [TIME_W-1:0] tcount_q, tcount_d, start_q, start_d, stop_q, stop_d;
  ts_delay_t delay, cnt_q, cnt_d;
`ifdef TS_MEAS_COUNT_EN
  logic [15:0] mc_q, mc_d;
  assign bus.meas_count = mc_q;
`endif
  ts_delay_model #(
    .TT_W(TT_W), .CAP_W(CAP_W), .D0(D0), .TT_SHIFT(TT_SHIFT), .CAP_SHIFT(CAP_SHIFT), .MAX_DELAY(MAX_DELAY)
  ) u_delay (
    .tt_val(bus.tt_val), .capa_charge_val(bus.capa_charge_val), .delay(delay)
  );
  assign new_target = &din_q;
  assign bus.dout = dout_q;
  assign bus.busy = busy_q;
  assign bus.start_time = start_q;
  assign bus.stop_time = stop_q;
  assign bus.meas_valid = mv_q;
  always_comb begin
    din_d = {bus.din1, bus.din0};
    target_d = target_q;
    dout_d = dout_q;
    busy_d = busy_q;
    mv_d = 1'b0;
    tcount_d = tcount_q;
    start_d = start_q;
    stop_d = stop_q;
    cnt_d = cnt_q;
`ifdef TS_MEAS_COUNT_EN
    mc_d = mc_q;
`endif
    if (!bus.fin_test) begin
      tcount_d = tcount_q + 1'b1;
      if (new_target != target_q) begin
        target_d = new_target;
        // an event back to the current output level is a glitch cancel
        busy_d = new_target != dout_q;
        if (new_target != dout_q) begin
          start_d = tcount_q;
          cnt_d = delay - 1'b1;
        end
      end else if (busy_q) begin
        if (cnt_q == '0) begin
          dout_d = target_q;
          stop_d = tcount_q;
          busy_d = 1'b0;
          mv_d = 1'b1;
`ifdef TS_MEAS_COUNT_EN
          mc_d = (mc_q == 16'hFFFF) ? mc_q : mc_q + 1'b1;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      din_q <= '0;
      target_q <= 1'b0;
      dout_q <= 1'b0;
      busy_q <= 1'b0;
      mv_q <= 1'b0;
      tcount_q <= '0;
      start_q <= '0;
      stop_q <= '0;
      cnt_q <= '0;
`ifdef TS_MEAS_COUNT_EN
      mc_q <= '0;
`endif
    end else begin
      din_q <= din_d;
      target_q <= target_d;
      dout_q <= dout_d;
      busy_q <= busy_d;
      mv_q <= mv_d;
      tcount_q <= tcount_d;
      start_q <= start_d;
      stop_q <= stop_d;
      cnt_q <= cnt_d;
`ifdef TS_MEAS_COUNT_EN
      mc_q <= mc_d;
`endif
    end
  end
endmodule

// File: tb/tb_timing_study_board.sv
// tb_timing_study_board: directed self-checking bench for timing_study_board
module tb_timing_study_board;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [31:0] tc;
  timing_study_board_if bus();
  timing_study_board dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) tc <= rst ? 32'd0 : (bus.fin_test ? tc : tc + 32'd1);

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_edge(input string name, input logic a, input int exp_d, input logic [15:0] cap_mid);
    int n;
    bus.din0 = a;
    step(2);
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL %s_busy: got %b want 1", name, bus.busy); end
    checks++;
    if (bus.start_time !== tc - 32'd1) begin
      errors++; $display("FAIL %s_start: got %0d want %0d", name, bus.start_time, tc - 32'd1);
    end
    bus.capa_charge_val = cap_mid;
    n = 0;
    while (bus.meas_valid !== 1'b1 && n < 1100) begin step(1); n++; end
    checks++;
    if (n !== exp_d) begin errors++; $display("FAIL %s_latency: got %0d want %0d", name, n, exp_d); end
    checks++;
    if (bus.stop_time - bus.start_time !== 32'(exp_d)) begin
      errors++; $display("FAIL %s_delta: got %0d want %0d", name, bus.stop_time - bus.start_time, exp_d);
    end
    checks++;
    if (bus.dout !== (a & bus.din1)) begin errors++; $display("FAIL %s_dout: got %b want %b", name, bus.dout, a & bus.din1); end
    step(1);
    checks++;
    if (bus.meas_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL %s_pulse: got mv=%b busy=%b want 0 0", name, bus.meas_valid, bus.busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(3);
    checks++;
    if ({bus.dout, bus.busy, bus.meas_valid} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b want 000", {bus.dout, bus.busy, bus.meas_valid});
    end
    checks++;
    if (bus.start_time !== 32'd0 || bus.stop_time !== 32'd0) begin
      errors++; $display("FAIL reset_times: got %0d/%0d want 0/0", bus.start_time, bus.stop_time);
    end
`ifdef TS_MEAS_COUNT_EN
    checks++;
    if (bus.meas_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.meas_count); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_basic();
    bus.tt_val = 16'd0;
    bus.capa_charge_val = 16'd0;
    bus.din1 = 1'b1;
    step(3);
    run_edge("t1_rise", 1'b1, 2, 16'd0);
    run_edge("t1_fall", 1'b0, 2, 16'd0);
  endtask

  task automatic test_slope_load();
    bus.tt_val = 16'd160;
    bus.capa_charge_val = 16'd640;
    step(1);
    run_edge("t2_rise", 1'b1, 22, 16'd0);
    run_edge("t2_fall", 1'b0, 12, 16'd0);
  endtask

  task automatic test_clamp();
    bus.tt_val = 16'hFFFF;
    bus.capa_charge_val = 16'hFFFF;
    step(1);
    run_edge("t3_rise", 1'b1, 1023, 16'hFFFF);
    run_edge("t3_fall", 1'b0, 1023, 16'hFFFF);
  endtask

  task automatic test_glitch();
    logic [31:0] st;
    logic seen_mv, seen_dout;
    bus.tt_val = 16'd160;
    bus.capa_charge_val = 16'd640;
    step(1);
    st = bus.stop_time;
    bus.din0 = 1'b1;
    step(2);
    checks++;
    if (bus.busy !== 1'b1 || bus.start_time !== tc - 32'd1) begin
      errors++; $display("FAIL glitch_start: got busy=%b start=%0d want 1 %0d", bus.busy, bus.start_time, tc - 32'd1);
    end
    step(1);
    bus.din0 = 1'b0;
    step(2);
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL glitch_cancel: got busy=%b want 0", bus.busy); end
    seen_mv = 1'b0;
    seen_dout = 1'b0;
    for (int i = 0; i < 30; i++) begin
      seen_mv |= bus.meas_valid;
      seen_dout |= bus.dout;
      step(1);
    end
    checks++;
    if (seen_mv !== 1'b0 || seen_dout !== 1'b0) begin
      errors++; $display("FAIL glitch_quiet: got mv=%b dout=%b want 0 0", seen_mv, seen_dout);
    end
    checks++;
    if (bus.stop_time !== st) begin errors++; $display("FAIL glitch_stop: got %0d want %0d", bus.stop_time, st); end
  endtask

  task automatic test_no_change();
    logic [31:0] st;
    logic seen_busy;
    bus.din1 = 1'b0;
    step(2);
    st = bus.start_time;
    seen_busy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.din0 = ~bus.din0;
      step(1);
      seen_busy |= bus.busy;
    end
    step(3);
    checks++;
    if (bus.start_time !== st) begin errors++; $display("FAIL nochg_start: got %0d want %0d", bus.start_time, st); end
    checks++;
    if (seen_busy !== 1'b0 || bus.dout !== 1'b0) begin
      errors++; $display("FAIL nochg_out: got busy=%b dout=%b want 0 0", seen_busy, bus.dout);
    end
    bus.din0 = 1'b0;
    step(2);
  endtask

  task automatic test_freeze_reset();
    int n;
    logic bad;
    bus.din1 = 1'b1;
    bus.tt_val = 16'd160;
    bus.capa_charge_val = 16'd640;
    bus.din0 = 1'b1;
    step(2);
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL freeze_busy: got %b want 1", bus.busy); end
    step(5);
    bus.fin_test = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      bad |= (bus.busy !== 1'b1) || (bus.dout !== 1'b0) || (bus.meas_valid !== 1'b0);
    end
    bus.fin_test = 1'b0;
    checks++;
    if (bad !== 1'b0) begin errors++; $display("FAIL freeze_hold: got state change, want hold"); end
    n = 15;
    while (bus.meas_valid !== 1'b1 && n < 1100) begin step(1); n++; end
    checks++;
    if (n !== 32) begin errors++; $display("FAIL freeze_latency: got %0d want 32", n); end
    checks++;
    if (bus.stop_time - bus.start_time !== 32'd22 || bus.dout !== 1'b1) begin
      errors++; $display("FAIL freeze_delta: got %0d dout=%b want 22 1", bus.stop_time - bus.start_time, bus.dout);
    end
`ifdef TS_MEAS_COUNT_EN
    checks++;
    if (bus.meas_count !== 16'd7) begin errors++; $display("FAIL meas_count: got %0d want 7", bus.meas_count); end
`endif
    bus.din0 = 1'b0;
    step(2);
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL rst_pending: got %b want 1", bus.busy); end
    step(3);
    rst = 1'b1;
    step(1);
    checks++;
    if ({bus.dout, bus.busy, bus.meas_valid} !== 3'b000) begin
      errors++; $display("FAIL rst_flags: got %b want 000", {bus.dout, bus.busy, bus.meas_valid});
    end
    checks++;
    if (bus.start_time !== 32'd0 || bus.stop_time !== 32'd0) begin
      errors++; $display("FAIL rst_times: got %0d/%0d want 0/0", bus.start_time, bus.stop_time);
    end
    rst = 1'b0;
    step(2);
  endtask

  initial begin
    bus.din0 = 1'b0;
    bus.din1 = 1'b0;
    bus.fin_test = 1'b0;
    bus.tt_val = 16'd0;
    bus.capa_charge_val = 16'd0;
    test_reset();
    test_basic();
    test_slope_load();
    test_clamp();
    test_glitch();
    test_no_change();
    test_freeze_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/timing_study_board.md
Name: timing_study_board

Overview:
Clocked, synthesizable stand-in for the AND2 propagation-delay characterisation board.
- Computes out = din0 & din1 and applies it to dout after a load/slope-dependent delay, a linear NLDM-style model.
- Timestamps each input event that changes the output (start_time) and the resulting output edge (stop_time).
- A sweep bench reads stop_time - start_time to build cell_rise/cell_fall tables.

Parameters:
TIME_W, 32, width of timestamp counter and start_time/stop_time
TT_W, 16, width of tt_val (input transition-time code)
CAP_W, 16, width of capa_charge_val (load-capacitance code)
D0, 2, intrinsic delay in cycles (must be >=1)
TT_SHIFT, 4, slope contribution = tt_val >> TT_SHIFT
CAP_SHIFT, 6, load contribution = capa_charge_val >> CAP_SHIFT
MAX_DELAY, 1023, delay saturation value in cycles

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
din0  in  1  gate input A1
din1  in  1  gate input A2
tt_val  in  TT_W  input transition-time code
capa_charge_val  in  CAP_W  load-capacitance code
fin_test  in  1  end of test; freezes the block while high
dout  out  1  delayed AND output
busy  out  1  an output transition is pending
start_time  out  TIME_W  timestamp of the last output-changing input event
stop_time  out  TIME_W  timestamp of the last completed output transition
meas_valid  out  1  one-cycle pulse when stop_time updates

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: tcount=0, dout=0, busy=0, start_time=0, stop_time=0, meas_valid=0, target=0, delay counter=0.
- Timestamp: tcount increments by 1 every cycle unless fin_test=1. It wraps modulo 2^TIME_W.
- Input sampling: din0/din1 are registered every edge into din_q. new_target = din_q0 & din_q1, compared against target.
- Delay computation is combinational on the current tt_val and capa_charge_val:
  - delay = D0 + (tt_val>>TT_SHIFT) + (capa_charge_val>>CAP_SHIFT), computed without overflow.
  - The result is clamped to MAX_DELAY.
- Event, when new_target != target and fin_test=0:
  - target<=new_target.
  - If new_target != dout: start_time<=tcount, cnt<=delay-1, busy<=1.
  - If new_target == dout: this is a glitch cancel. busy<=0, stop_time untouched, no meas_valid.
- Inertial behaviour: a new event while busy restarts the measurement with the delay recomputed at that edge.
- Input stability: tt_val and capa_charge_val are only sampled at the event edge. Changes while busy are ignored.
- Pending countdown: while busy and fin_test=0, cnt decrements each cycle. In the cycle cnt==0:
  - dout<=target, stop_time<=tcount, busy<=0, meas_valid<=1 for one cycle.
  - Result: stop_time - start_time == delay exactly, mod 2^TIME_W.
- Inputs that do not change the AND result start no measurement, e.g. din0 toggling while din1=0.
- fin_test=1 freezes the block:
  - tcount, cnt, dout, busy, start_time and stop_time all hold.
  - Events are ignored.
  - din_q still samples, so a pending difference is processed after fin_test falls.
- Reset mid-operation: a pending transition is discarded and all outputs return to their reset values.

Optional Feature:
TS_MEAS_COUNT_EN
- Defined: adds output meas_count [15:0], reset 0, incremented on each meas_valid. It saturates at 0xFFFF and holds under fin_test.
- Undefined: the port and its counter are absent, and the behaviour is otherwise identical.

Decomposition:
- Package timing_study_pkg holds:
  - default width constants TIME_W, TT_W, CAP_W;
  - typedef ts_time_t;
  - function calc_delay(tt, cap, d0, tt_shift, cap_shift, max), which performs the saturating sum.
- One combinational sub-module, ts_delay_model, wraps calc_delay (inputs tt_val, capa_charge_val; output delay).
- The top holds the sampling, timestamp, countdown and measurement registers.

Test Plan:
1. tt=0, cap=0, din1=1, din0 0->1 -> dout rises, busy for 2 cycles, stop_time-start_time=2, meas_valid pulses once. Then din0 1->0 -> dout falls with delta 2.
2. tt=160, cap=640, din1=1, din0 rises -> delay 2+10+10=22, stop-start=22. Change cap to 0 mid-pending -> delta still 22.
3. tt=0xFFFF, cap=0xFFFF -> delay clamped to 1023, stop-start=1023.
4. Glitch: delay 22, din0 pulsed high for 3 cycles -> start_time updated, dout stays 0, busy clears, stop_time unchanged, no meas_valid.
5. din1=0, toggle din0 several times -> no start_time change, dout=0, busy=0.
6. Freeze and reset:
   - fin_test=1 for 10 cycles mid-pending -> tcount and cnt frozen; after release stop-start=delay.
   - rst asserted mid-pending -> all outputs 0 the next cycle.
